feed_ab: RTL and testbench
==========================

// Module: feed_AB
// PURPOSE
// - Source end of the PE-chain A/B FIFO links: streams one tile's A and B operands from two local memories into the first PE.
// - Per k-step it sends 2**A_NUM_WIDTH A elements on the A link and 2**B_NUM_WIDTH B elements on the B link.
// - The links are independent; each is a valid/pass-enable link that this block drives as transmitter.
// PARAMETERS
// - D_WIDTH      64  operand width
// - A_NUM_WIDTH  1   log2 S_i; A elements per k-step = 2**A_NUM_WIDTH
// - B_NUM_WIDTH  1   log2 S_j; B elements per k-step = 2**B_NUM_WIDTH
// - K_WIDTH      8   width of k_len
// - MEM_LAT      2   memory read latency in cycles; rd_data valid MEM_LAT cycles after rd_en
// PORTS
// - clk                 in   1              clock; only clock
// - rst_n               in   1              async active-low reset
// - start               in   1              1-cycle pulse; begin a tile (ignored while busy)
// - k_len               in   K_WIDTH        k-steps per tile; sampled on accepted start
// - busy                out  1              tile in progress
// - done                out  1              1-cycle pulse when the last A and B elements are accepted
// - a_rd_en             out  1              A memory read strobe
// - a_rd_addr           out  K_WIDTH+A_NUM_WIDTH  A address = k*S_i + i, linear
// - a_rd_data           in   D_WIDTH        A read data
// - b_rd_en             out  1              B memory read strobe
// - b_rd_addr           out  K_WIDTH+B_NUM_WIDTH  B address = k*S_j + j, linear
// - b_rd_data           in   D_WIDTH        B read data
// - data_A_FIFO_out     out  D_WIDTH        A element to PE chain
// - valid_A_FIFO_out    out  1              A element available
// - PASS_EN_A_FIFO_in   in   1              PE accepts A this cycle
// - data_B_FIFO_out / valid_B_FIFO_out / PASS_EN_B_FIFO_in: same as A, for B
// BEHAVIOUR
// - Reset: busy=0, done=0, rd_en=0, rd_addr=0, valid_*=0, data_*=0; FSM=IDLE; all counters and buffers cleared. Reset mid-tile abandons the tile; in-flight read data arriving after reset is discarded.
// - FSM IDLE -> RUN on start when !busy; k_len latched; A and B totals = k_len<<A_NUM_WIDTH and k_len<<B_NUM_WIDTH.
// - IDLE -> DONE directly if k_len==0: no reads, no valid.
// - RUN -> DONE when both channels have had their final element accepted.
// - DONE -> IDLE next cycle; done=1 only in DONE. busy=1 in RUN and DONE.
// - Transfer: an element moves when valid && PASS_EN in the same cycle.
// - While valid=1 and PASS_EN=0, data is held stable and valid stays high.
// - PASS_EN with valid=0 is ignored.
// - Per channel: prefetch buffer of depth MEM_LAT+1 with credits; issue read iff issued_count < total && (occupancy + in_flight) < MEM_LAT+1.
// - Sustains 1 element/cycle with PASS_EN held high; never overflows.
// - Read data is pushed into the buffer exactly MEM_LAT cycles after its rd_en, tracked by a MEM_LAT-deep shift register.
// - Latency: start -> first rd_en 1 cycle; first valid at 1+MEM_LAT+1 cycles after start (registered output).
// - Addresses issue in order 0..total-1; the issue counter stops at total. No wrap within a tile; the next tile restarts at 0.
// - A and B never block each other; one channel may finish and idle while the other stalls.
// - The last-element acceptance cycle and the DONE transition are simultaneous: done asserts the following cycle.
// - A start pulse on the same cycle as done is ignored; start is accepted only in IDLE.
// CONFIGURATION
// - FEED_STALL_CNT_EN defined: adds outputs a_stall_cnt, b_stall_cnt [31:0], saturating.
//   - Each counts cycles with valid_*_FIFO_out && !PASS_EN_*_FIFO_in.
//   - Both cleared on accepted start and on reset.
// - Undefined: ports and logic absent; all other behaviour identical.
// TESTING
// - Reset, A_NUM_WIDTH=1, B_NUM_WIDTH=1, k_len=3, PASS_EN always 1, mem[i]=i
//   -> A link 0,1,2,3,4,5 on consecutive cycles; B link same; done pulses once; busy falls the cycle after done.
// - k_len=0 start -> done 1 cycle after start; no rd_en; valid never asserts.
// - PASS_EN_A held 0 for 10 cycles mid-tile
//   -> data_A held stable; a_rd_en stops after the buffer plus in-flight reach MEM_LAT+1; B unaffected; no element lost or duplicated.
// - PASS_EN_A random 50% / PASS_EN_B random 30%, k_len=16
//   -> scoreboard matches address-ordered sequence on each link; done after both finish.
// - rst_n asserted 2 cycles after the first rd_en
//   -> all outputs at reset values immediately; a new start yields a clean sequence from address 0.
// - FEED_STALL_CNT_EN, PASS_EN_B low 7 cycles while valid_B=1 -> b_stall_cnt=7, a_stall_cnt=0.

Source files
------------

// File: rtl/feed_ab.sv
// -----------------------------------------------------------------------------
// feed_ab
// Source end of the PE-chain A/B operand links. For one tile it reads k_len
// k-steps of operands from two local memories and streams them to the first
// PE: 2**A_NUM_WIDTH A elements and 2**B_NUM_WIDTH B elements per k-step.
// Each link is a valid / pass-enable link driven by this block as transmitter.
// The two links run independently; either may stall without holding up the
// other.
//
// Optional build macro: FEED_STALL_CNT_EN
//   When defined, adds saturating stall counters a_stall_cnt / b_stall_cnt
//   that count cycles where an element is offered but not accepted.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, k_len                tile start pulse and k-step count (IDLE only)
//   busy, done                  tile in progress / one-cycle completion pulse
//   a_rd_en/a_rd_addr/a_rd_data A memory read port (data MEM_LAT after en)
//   b_rd_en/b_rd_addr/b_rd_data B memory read port
//   data_A_FIFO_out, valid_A_FIFO_out, PASS_EN_A_FIFO_in   A link
//   data_B_FIFO_out, valid_B_FIFO_out, PASS_EN_B_FIFO_in   B link
//   a_stall_cnt, b_stall_cnt    (FEED_STALL_CNT_EN only) stall cycle counts
// -----------------------------------------------------------------------------
module feed_ab #(
  parameter int D_WIDTH     = 64,
  parameter int A_NUM_WIDTH = 1,
  parameter int B_NUM_WIDTH = 1,
  parameter int K_WIDTH     = 8,
  parameter int MEM_LAT     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [K_WIDTH-1:0]             k_len,
  output logic                           busy,
  output logic                           done,
  output logic                           a_rd_en,
  output logic [K_WIDTH+A_NUM_WIDTH-1:0] a_rd_addr,
  input  logic [D_WIDTH-1:0]             a_rd_data,
  output logic                           b_rd_en,
  output logic [K_WIDTH+B_NUM_WIDTH-1:0] b_rd_addr,
  input  logic [D_WIDTH-1:0]             b_rd_data,
  output logic [D_WIDTH-1:0]             data_A_FIFO_out,
  output logic                           valid_A_FIFO_out,
  input  logic                           PASS_EN_A_FIFO_in,
  output logic [D_WIDTH-1:0]             data_B_FIFO_out,
  output logic                           valid_B_FIFO_out,
  input  logic                           PASS_EN_B_FIFO_in
`ifdef FEED_STALL_CNT_EN
  ,
  output logic [31:0]                    a_stall_cnt,
  output logic [31:0]                    b_stall_cnt
`endif
);

  localparam int AAW   = K_WIDTH + A_NUM_WIDTH;
  localparam int BAW   = K_WIDTH + B_NUM_WIDTH;
  // Common counter width for both channels (the wider of the two).
  localparam int CAW   = K_WIDTH + ((A_NUM_WIDTH > B_NUM_WIDTH) ? A_NUM_WIDTH : B_NUM_WIDTH);
  localparam int DEPTH = MEM_LAT + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough to hold occupancy + in-flight without wrapping.
  localparam int CW    = $clog2(DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [K_WIDTH-1:0] k_len_q;
  logic               accept;
  logic               run;

  // Per-channel views: index 0 = A, index 1 = B.
  logic [CAW-1:0]     total_c [2];
  logic [D_WIDTH-1:0] rdata_c [2];
  logic [D_WIDTH-1:0] data_c  [2];
  logic [CAW-1:0]     addr_c  [2];
  logic [1:0]         pass_v;
  logic [1:0]         rd_en_v;
  logic [1:0]         valid_v;
  logic [1:0]         fin_v;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept     = start && (state == IDLE);
  assign run        = (state == RUN);
  assign total_c[0] = CAW'(k_len_q) << A_NUM_WIDTH;
  assign total_c[1] = CAW'(k_len_q) << B_NUM_WIDTH;
  assign rdata_c[0] = a_rd_data;
  assign rdata_c[1] = b_rd_data;
  assign pass_v     = {PASS_EN_B_FIFO_in, PASS_EN_A_FIFO_in};

  // --- control FSM ---------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k_len_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) k_len_q <= k_len;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (k_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        // fin_v already includes an acceptance happening this cycle, so
        // done lands exactly one cycle after the last element moves.
        if (&fin_v) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --- per-channel prefetch: issue, in-flight tracking, buffer, output ------
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [CAW-1:0]     issued;
    logic [CAW-1:0]     accepted;
    logic [MEM_LAT-1:0] pend;
    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      occ;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      occ_eff;
    logic               pop;
    logic               push;
    logic               issue;

    // pend[k] marks a read issued k+1 cycles ago; the oldest slot lines up
    // with the cycle its data is on rd_data.
    assign push = pend[MEM_LAT-1];
    assign pop  = (occ != '0) && pass_v[c];

    always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CW'(pend[i]);
    end

    // The slot vacated by this cycle's pop counts as free credit; without it
    // a DEPTH-entry buffer could not sustain one element per cycle.
    assign occ_eff = occ - CW'(pop);
    assign issue   = run && (issued < total_c[c]) && ((occ_eff + inflight) < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        issued   <= '0;
        accepted <= '0;
        pend     <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        occ      <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (accept) begin
        issued   <= '0;
        accepted <= '0;
        pend     <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        occ      <= '0;
      end else begin
        pend <= (pend << 1) | MEM_LAT'(issue);
        if (issue) issued <= issued + 1'b1;
        if (push) begin
          mem_q[wr_ptr] <= rdata_c[c];
          wr_ptr        <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr   <= ptr_inc(rd_ptr);
          accepted <= accepted + 1'b1;
        end
        occ <= occ + CW'(push) - CW'(pop);
      end
    end

    assign rd_en_v[c] = issue;
    assign addr_c[c]  = issued;
    assign valid_v[c] = (occ != '0);
    assign data_c[c]  = mem_q[rd_ptr];
    assign fin_v[c]   = (accepted == total_c[c]) ||
                        (pop && (accepted == total_c[c] - CAW'(1)));
  end

  assign a_rd_en          = rd_en_v[0];
  assign a_rd_addr        = addr_c[0][AAW-1:0];
  assign b_rd_en          = rd_en_v[1];
  assign b_rd_addr        = addr_c[1][BAW-1:0];
  assign data_A_FIFO_out  = data_c[0];
  assign valid_A_FIFO_out = valid_v[0];
  assign data_B_FIFO_out  = data_c[1];
  assign valid_B_FIFO_out = valid_v[1];

`ifdef FEED_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // --- stall counters ------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_stall_cnt <= '0;
      b_stall_cnt <= '0;
    end else if (accept) begin
      a_stall_cnt <= '0;
      b_stall_cnt <= '0;
    end else begin
      if (valid_v[0] && !pass_v[0]) a_stall_cnt <= sat_inc(a_stall_cnt);
      if (valid_v[1] && !pass_v[1]) b_stall_cnt <= sat_inc(b_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_feed_ab.sv
// -----------------------------------------------------------------------------
// tb_feed_ab
// Self-checking bench for feed_ab. A transaction-level model (expected element
// sequence per link, tile busy/done timing, credit bound) is compared against
// the DUT on every negative clock edge; directed tests add literal timing and
// count expectations.
// -----------------------------------------------------------------------------
module tb_feed_ab;
  localparam int DW      = 64;
  localparam int ANW     = 1;
  localparam int BNW     = 1;
  localparam int KW      = 8;
  localparam int MEM_LAT = 2;
  localparam int DEPTH   = MEM_LAT + 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              busy;
  logic              done;
  logic              a_rd_en;
  logic [KW+ANW-1:0] a_rd_addr;
  logic [DW-1:0]     a_rd_data;
  logic              b_rd_en;
  logic [KW+BNW-1:0] b_rd_addr;
  logic [DW-1:0]     b_rd_data;
  logic [DW-1:0]     data_A;
  logic              valid_A;
  logic              PASS_A;
  logic [DW-1:0]     data_B;
  logic              valid_B;
  logic              PASS_B;
`ifdef FEED_STALL_CNT_EN
  logic [31:0]       a_stall_cnt;
  logic [31:0]       b_stall_cnt;
`endif

  feed_ab #(
    .D_WIDTH(DW), .A_NUM_WIDTH(ANW), .B_NUM_WIDTH(BNW), .K_WIDTH(KW), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .data_A_FIFO_out(data_A), .valid_A_FIFO_out(valid_A), .PASS_EN_A_FIFO_in(PASS_A),
    .data_B_FIFO_out(data_B), .valid_B_FIFO_out(valid_B), .PASS_EN_B_FIFO_in(PASS_B)
`ifdef FEED_STALL_CNT_EN
    ,
    .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit pat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_a(input int i);
    return pat ? (64'hA5A5_0000_0000_0000 | 64'(i)) : 64'(i);
  endfunction
  function automatic logic [63:0] exp_b(input int i);
    return pat ? (64'h5B5B_0000_0000_0000 | 64'(i)) : 64'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_b(input string name, input bit cond);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s actual=0 required=1", name);
    end
  endtask

  // Memory model: contents fixed by the pattern at issue time, returned
  // MEM_LAT cycles after the read strobe. Garbage when nothing was read.
  logic [63:0] a_dl [MEM_LAT];
  logic [63:0] b_dl [MEM_LAT];
  always @(posedge clk) begin
    a_dl[0] <= a_rd_en ? exp_a(int'(a_rd_addr)) : 64'hDEAD_BEEF_DEAD_BEEF;
    b_dl[0] <= b_rd_en ? exp_b(int'(b_rd_addr)) : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i < MEM_LAT; i++) begin
      a_dl[i] <= a_dl[i-1];
      b_dl[i] <= b_dl[i-1];
    end
  end
  assign a_rd_data = a_dl[MEM_LAT-1];
  assign b_rd_data = b_dl[MEM_LAT-1];

  // Model state
  bit          m_busy = 0, m_done = 0, prev_busy = 0, valid_seen = 0;
  int          m_start = 0, done_cnt = 0, done_cyc = -1, busy_fall = -1;
  int          a_tot = 0, a_iss = 0, a_idx = 0, a_first = -1;
  int          b_tot = 0, b_iss = 0, b_idx = 0, b_first = -1;
  bit          a_hold = 0, b_hold = 0;
  logic [63:0] a_hold_val, b_hold_val;
  int          a_cyc [64];
  int          b_cyc [64];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctl", 64'({busy, done, a_rd_en, b_rd_en, valid_A, valid_B}), 64'd0);
      check("rst_addr", 64'({a_rd_addr, b_rd_addr}), 64'd0);
      check("rst_data_a", data_A, 64'd0);
      check("rst_data_b", data_B, 64'd0);
      m_busy = 0; m_done = 0; prev_busy = 0; a_hold = 0; b_hold = 0;
      a_tot = 0; a_iss = 0; a_idx = 0; b_tot = 0; b_iss = 0; b_idx = 0;
    end else begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;
      if (valid_A || valid_B) valid_seen = 1;
      // A link
      if (a_rd_en) begin
        check_b("a_rd_in_run", m_busy && !m_done && (a_iss < a_tot));
        check("a_addr", 64'(a_rd_addr), 64'(a_iss));
        if (a_iss == 0) a_first = cyc;
        a_iss++;
      end
      if (a_hold) begin
        check("a_hold_vld", 64'(valid_A), 64'd1);
        check("a_hold_data", data_A, a_hold_val);
      end
      if (valid_A && PASS_A) begin
        check_b("a_extra", a_idx < a_tot);
        check("a_data", data_A, exp_a(a_idx));
        if (a_idx < 64) a_cyc[a_idx] = cyc;
        a_idx++;
      end
      check_b("a_credit", (a_iss - a_idx) <= DEPTH);
      a_hold = valid_A && !PASS_A;
      a_hold_val = data_A;
      // B link
      if (b_rd_en) begin
        check_b("b_rd_in_run", m_busy && !m_done && (b_iss < b_tot));
        check("b_addr", 64'(b_rd_addr), 64'(b_iss));
        if (b_iss == 0) b_first = cyc;
        b_iss++;
      end
      if (b_hold) begin
        check("b_hold_vld", 64'(valid_B), 64'd1);
        check("b_hold_data", data_B, b_hold_val);
      end
      if (valid_B && PASS_B) begin
        check_b("b_extra", b_idx < b_tot);
        check("b_data", data_B, exp_b(b_idx));
        if (b_idx < 64) b_cyc[b_idx] = cyc;
        b_idx++;
      end
      check_b("b_credit", (b_iss - b_idx) <= DEPTH);
      b_hold = valid_B && !PASS_B;
      b_hold_val = data_B;
      // Tile-level model for the next cycle
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_start = cyc; done_cnt = 0; valid_seen = 0;
          a_tot = int'(k_len) << ANW; b_tot = int'(k_len) << BNW;
          a_iss = 0; a_idx = 0; b_iss = 0; b_idx = 0;
          a_first = -1; b_first = -1; done_cyc = -1; busy_fall = -1;
          if (k_len == 0) m_done = 1;
        end
      end else if ((a_idx == a_tot) && (b_idx == b_tot)) begin
        m_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || m_busy) && n < 3000) begin tick(); n++; end
    check_b({name, "_timeout"}, n < 3000);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    rst_n = 1'b1; start = 1'b0; k_len = '0; PASS_A = 1'b1; PASS_B = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("init_busy", 64'(busy), 64'd0);
    check("init_valid", 64'({valid_A, valid_B}), 64'd0);
    rst_n = 1'b1;
    tick();

    // k_len=3, mem[i]=i, PASS_EN high: 6 elements per link back to back.
    do_start(3);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check("t1_done_seen", 64'(done), 64'd1);
    start = 1'b1; k_len = 8'd5;   // must be ignored: coincides with done
    tick();
    start = 1'b0;
    wait_idle("t1");
    check("t1_first_rd_a", 64'(a_first), 64'(m_start + 1));
    check("t1_first_rd_b", 64'(b_first), 64'(m_start + 1));
    for (int j = 0; j < 6; j++) begin
      check("t1_a_cycle", 64'(a_cyc[j]), 64'(m_start + 4 + j));
      check("t1_b_cycle", 64'(b_cyc[j]), 64'(m_start + 4 + j));
    end
    check("t1_a_count", 64'(a_idx), 64'd6);
    check("t1_b_count", 64'(b_idx), 64'd6);
    check("t1_done_cyc", 64'(done_cyc), 64'(m_start + 10));
    check("t1_busy_fall", 64'(busy_fall), 64'(m_start + 11));
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // k_len=0: done one cycle after start, no reads, no valid.
    do_start(0);
    wait_idle("t2");
    check("t2_done_cyc", 64'(done_cyc), 64'(m_start + 1));
    check("t2_no_rd", 64'(a_iss + b_iss), 64'd0);
    check("t2_no_valid", 64'(valid_seen), 64'd0);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);

    // A stalled 10 cycles mid-tile; B keeps flowing.
    pat = 1'b1;
    do_start(8);
    repeat (4) tick();
    PASS_A = 1'b0;
    b0 = b_idx;
    repeat (10) tick();
    check("t3_b_progress", 64'(b_idx - b0), 64'd10);
    check("t3_a_outstanding", 64'(a_iss - a_idx), 64'(DEPTH));
    check("t3_a_rd_stopped", 64'(a_rd_en), 64'd0);
    check("t3_a_valid_held", 64'(valid_A), 64'd1);
    PASS_A = 1'b1;
    wait_idle("t3");
    check("t3_a_count", 64'(a_idx), 64'd16);
    check("t3_b_count", 64'(b_idx), 64'd16);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);

    // Random back-pressure: A 50%, B 30% acceptance, k_len=16.
    do_start(16);
    n = 0;
    while ((busy || m_busy) && n < 3000) begin
      PASS_A = ($urandom_range(0, 99) < 50);
      PASS_B = ($urandom_range(0, 99) < 30);
      tick();
      n++;
    end
    check_b("t4_timeout", n < 3000);
    PASS_A = 1'b1; PASS_B = 1'b1;
    tick();
    check("t4_a_count", 64'(a_idx), 64'd32);
    check("t4_b_count", 64'(b_idx), 64'd32);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);

    // Reset two cycles after the first read strobe, then a clean tile.
    pat = 1'b0;
    do_start(4);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'({busy, done}), 64'd0);
    check("t5_rst_rd", 64'({a_rd_en, b_rd_en}), 64'd0);
    check("t5_rst_addr", 64'({a_rd_addr, b_rd_addr}), 64'd0);
    check("t5_rst_valid", 64'({valid_A, valid_B}), 64'd0);
    check("t5_rst_data", data_A | data_B, 64'd0);
`ifdef FEED_STALL_CNT_EN
    check("t5_rst_stall", 64'({a_stall_cnt, b_stall_cnt}), 64'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pat = 1'b1;
    do_start(2);
    wait_idle("t5");
    check("t5_first_rd", 64'(a_first), 64'(m_start + 1));
    check("t5_a_count", 64'(a_idx), 64'd4);
    check("t5_b_count", 64'(b_idx), 64'd4);

`ifdef FEED_STALL_CNT_EN
    // B held off 7 cycles while valid.
    do_start(8);
    repeat (3) tick();
    PASS_B = 1'b0;
    repeat (7) tick();
    PASS_B = 1'b1;
    wait_idle("t6");
    check("t6_b_stall", 64'(b_stall_cnt), 64'd7);
    check("t6_a_stall", 64'(a_stall_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
